dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-port data memory responder with fixed-latency response handshake
//
// Purpose: word-organised storage (2**addr_width_p x 32 bits) serving one core
// request at a time. A request is accepted only in IDLE. Stores commit on the
// acceptance edge. Load data is captured into the response register on that
// same edge. The response is presented latency_p cycles later and is held
// until the core consumes it.
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned word accesses.
// When it is defined, such accesses set a sticky err_o, are not written, and
// return zero.
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset          synchronous, active-low
//   req_valid_i    core presents a request
//   req_wen_i      1 = store, 0 = load
//   req_byte_i     1 = byte access, 0 = word access
//   req_addr_i     byte address; word index is addr[addr_width_p+1:2]
//   req_wdata_i    store data; byte stores use bits [7:0]
//   rsp_yumi_i     core consumes the pending response
//   req_yumi_o     request accepted this cycle
//   rsp_valid_o    response pending
//   rsp_rdata_o    load data, 0 for stores
//   busy_o         high in any state other than IDLE
//   err_o          sticky access-error flag
`timescale 1ns/1ps
module dmem_responder #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    input  logic        req_wen_i,
    input  logic        req_byte_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        rsp_yumi_i,
    output logic        req_yumi_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam logic [3:0] LAT_M1 = 4'(latency_p - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem_q [0:(1 << addr_width_p) - 1];

    logic [addr_width_p-1:0] idx;
    logic [1:0]              lane;
    logic [31:0]             rd_word;
    logic [31:0]             wr_word;
    logic [31:0]             ld_data;
    logic                    misaligned;
    logic                    accept;
    logic                    store_en;
    logic                    unused_addr_hi;

    assign idx            = req_addr_i[addr_width_p+1:2];
    assign lane           = req_addr_i[1:0];
    assign rd_word        = mem_q[idx];
    assign unused_addr_hi = ^req_addr_i[31:addr_width_p+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = ~req_byte_i & (lane != 2'd0);
`else
    assign misaligned = 1'b0;
`endif

    // Acceptance is also gated by reset so nothing commits during a reset cycle.
    assign accept     = (state_q == IDLE) & req_valid_i & reset;
    assign req_yumi_o = accept;
    assign store_en   = accept & req_wen_i & ~misaligned;

    // Byte stores are a read-modify-write of the addressed word.
    always_comb begin
        wr_word = rd_word;
        ld_data = rd_word;
        if (req_byte_i) begin
            wr_word[lane*8 +: 8] = req_wdata_i[7:0];
            ld_data              = {24'd0, rd_word[lane*8 +: 8]};
        end else begin
            wr_word = req_wdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = LAT_M1;
                    rdata_d = (req_wen_i | misaligned) ? 32'd0 : ld_data;
                    state_d = (latency_p == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // The edge that takes the counter to zero is the one that enters RESP,
                // so the response appears latency_p cycles after acceptance.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem_q[idx] <= wr_word;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept & misaligned) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
`timescale 1ns/1ps
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_wen_i = 1'b0;
    logic        req_byte_i = 1'b0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic        rsp_yumi_i = 1'b0;
    logic        req_yumi_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        busy_o;
    logic        err_o;

    dmem_responder #(.addr_width_p(10), .latency_p(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid_i(req_valid_i),
        .req_wen_i  (req_wen_i),
        .req_byte_i (req_byte_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_yumi_i (rsp_yumi_i),
        .req_yumi_o (req_yumi_o),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One complete request/response, with `hold` cycles of response backpressure.
    task automatic txn(input bit wen, input bit byt, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold,
                       output logic [31:0] rdata, output int lat);
        int n;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_wen_i   = wen;
        req_byte_i  = byt;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        #1;
        n = 0;
        while (req_yumi_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_accept", {31'd0, req_yumi_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        lat = 1;
        while (rsp_valid_o !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata_o;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid_rdata", {rsp_valid_o, rsp_rdata_o[30:0]}, {1'b1, rdata[30:0]});
        end
        rsp_yumi_i = 1'b1;
        @(negedge clk);
        rsp_yumi_i = 1'b0;
        chk("idle_after_yumi", {30'd0, busy_o, rsp_valid_o}, 32'd0);
    endtask

    typedef struct {
        bit          wen;
        bit          byt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [13];
    logic [31:0] model [int];
    logic [31:0] rd, held, w;
    int          lat;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 1'b0, 32'h10,   32'h12345678, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 32'h10,   32'h0,        32'h12345678};
        vt[2]  = '{1'b1, 1'b0, 32'h20,   32'hAABBCCDD, 32'h0};
        vt[3]  = '{1'b1, 1'b1, 32'h21,   32'hFFFFFF11, 32'h0};
        vt[4]  = '{1'b0, 1'b0, 32'h20,   32'h0,        32'hAABB11DD};
        vt[5]  = '{1'b0, 1'b1, 32'h23,   32'h0,        32'h000000AA};
        vt[6]  = '{1'b0, 1'b1, 32'h20,   32'h0,        32'h000000DD};
        vt[7]  = '{1'b1, 1'b0, 32'h1004, 32'h5,        32'h0};
        vt[8]  = '{1'b0, 1'b0, 32'h4,    32'h0,        32'h5};
        vt[9]  = '{1'b1, 1'b0, 32'h30,   32'h01020304, 32'h0};
        vt[10] = '{1'b1, 1'b0, 32'h32,   32'hFFFFFFFF, 32'h0};
        vt[11] = '{1'b0, 1'b0, 32'h30,   32'h0,        ALIGN ? 32'h01020304 : 32'hFFFFFFFF};
        vt[12] = '{1'b0, 1'b0, 32'h33,   32'h0,        ALIGN ? 32'h0 : 32'hFFFFFFFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'd0, req_yumi_o, rsp_valid_o, busy_o, err_o, 1'b0}, 32'd0);
        chk("reset_rdata", rsp_rdata_o, 32'd0);
        reset = 1'b1;

        // Directed vectors
        foreach (vt[i]) begin
            txn(vt[i].wen, vt[i].byt, vt[i].addr, vt[i].wdata, 0, rd, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
        end
        chk("err_after_misaligned", {31'd0, err_o}, {31'd0, ALIGN});

        // Backpressure: response held, requests ignored, no accept in the yumi cycle
        @(negedge clk);
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_byte_i = 1'b0; req_addr_i = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_addr_i = 32'h20;
        @(negedge clk);
        held = rsp_rdata_o;
        chk("bp_first_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("bp_first_rdata", held, 32'h12345678);
        for (int c = 0; c < 5; c++) begin
            req_addr_i = $urandom;
            #1;
            chk("bp_no_accept", {31'd0, req_yumi_o}, 32'd0);
            chk("bp_stable", {rsp_valid_o, rsp_rdata_o[30:0]}, {1'b1, held[30:0]});
            chk("bp_rdata_msb", {31'd0, rsp_rdata_o[31]}, {31'd0, held[31]});
            @(negedge clk);
        end
        rsp_yumi_i = 1'b1;
        #1;
        chk("bp_no_accept_yumi", {31'd0, req_yumi_o}, 32'd0);
        @(negedge clk);
        rsp_yumi_i = 1'b0;
        req_valid_i = 1'b0;
        #1;
        chk("bp_idle", {30'd0, busy_o, rsp_valid_o}, 32'd0);

        // Reset mid-WAIT
        txn(1'b1, 1'b0, 32'h40, 32'hCAFEBABE, 0, rd, lat);
        @(negedge clk);
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_addr_i = 32'h44;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("midwait_busy", {31'd0, busy_o}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("midwait_reset", {29'd0, busy_o, rsp_valid_o, err_o}, 32'd0);
        chk("midwait_rdata", rsp_rdata_o, 32'd0);
        reset = 1'b1;
        txn(1'b0, 1'b0, 32'h40, 32'h0, 0, rd, lat);
        chk("midwait_retained", rd, 32'hCAFEBABE);

        // Randomized traffic against a word-array model
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            txn(1'b1, 1'b0, (32'h100 + i) << 2, w, 0, rd, lat);
            model[32'h100 + i] = w;
        end
        for (int t = 0; t < 150; t++) begin
            bit          wen, byt;
            int          k, ln, wi;
            logic [31:0] a, d, e;
            wen = 1'($urandom % 2);
            byt = 1'($urandom % 2);
            k   = $urandom % 16;
            ln  = $urandom % 4;
            if (!byt && ALIGN) ln = 0;
            wi  = 32'h100 + k;
            a   = ($urandom << 12) | (wi << 2) | ln;
            d   = $urandom;
            if (wen) begin
                e = 32'd0;
                if (byt) begin
                    w = model[wi];
                    w[ln*8 +: 8] = d[7:0];
                    model[wi] = w;
                end else begin
                    model[wi] = d;
                end
            end else begin
                e = byt ? ((model[wi] >> (8 * ln)) & 32'hFF) : model[wi];
            end
            txn(wen, byt, a, d, $urandom % 3, rd, lat);
            chk($sformatf("rand%0d_rdata", t), rd, e);
            chk($sformatf("rand%0d_latency", t), lat, LAT);
        end
        chk("err_final", {31'd0, err_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
